// File: rtl/membus_arbiter.sv
// Two-to-one arbiter between the instruction-fetch and data buses onto one memory bus.
// Tracks the single outstanding request so each response goes back to the master that issued it.
module membus_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  // instruction-fetch bus
  input  logic                    i_ibus_valid,
  output logic                    o_ibus_ready,
  input  logic [ADDR_WIDTH-1:0]   i_ibus_addr,
  input  logic                    i_ibus_wen,
  input  logic [DATA_WIDTH-1:0]   i_ibus_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_ibus_wmask,
  output logic [DATA_WIDTH-1:0]   o_ibus_rdata,
  output logic                    o_ibus_rvalid,
  // data bus
  input  logic                    i_dbus_valid,
  output logic                    o_dbus_ready,
  input  logic [ADDR_WIDTH-1:0]   i_dbus_addr,
  input  logic                    i_dbus_wen,
  input  logic [DATA_WIDTH-1:0]   i_dbus_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_dbus_wmask,
  output logic [DATA_WIDTH-1:0]   o_dbus_rdata,
  output logic                    o_dbus_rvalid,
  // shared memory bus
  output logic                    o_mem_valid,
  input  logic                    i_mem_ready,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic                    o_mem_wen,
  output logic [DATA_WIDTH-1:0]   o_mem_wdata,
  output logic [DATA_WIDTH/8-1:0] o_mem_wmask,
  input  logic [DATA_WIDTH-1:0]   i_mem_rdata,
  input  logic                    i_mem_rvalid,
  output logic                    err
);

  typedef enum logic [1:0] {OWN_IDLE, OWN_I, OWN_D} owner_t;
  typedef enum logic [1:0] {LOCK_NONE, LOCK_I, LOCK_D} lock_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  owner_t     r_owner, w_owner_next;
  lock_t      r_lock, w_lock_next;
  logic [3:0] r_starve, w_starve_next;
  logic       r_err, w_err_next;

  logic w_grant_i, w_grant_d, w_can_issue, w_mem_valid, w_accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner  <= OWN_IDLE;
      r_lock   <= LOCK_NONE;
      r_starve <= 4'd0;
      r_err    <= 1'b0;
    end else begin
      r_owner  <= w_owner_next;
      r_lock   <= w_lock_next;
      r_starve <= w_starve_next;
      r_err    <= w_err_next;
    end
  end

  // A locked request keeps its grant so fields never change before acceptance.
  always_comb begin
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    if (r_lock == LOCK_I) begin
      w_grant_i = 1'b1;
    end else if (r_lock == LOCK_D) begin
      w_grant_d = 1'b1;
    end else if (i_ibus_valid && i_dbus_valid) begin
      if (r_starve == LIMIT) w_grant_i = 1'b1;
      else                   w_grant_d = 1'b1;
    end else if (i_ibus_valid) begin
      w_grant_i = 1'b1;
    end else if (i_dbus_valid) begin
      w_grant_d = 1'b1;
    end
  end

  assign w_can_issue = (r_owner == OWN_IDLE) || i_mem_rvalid;
  assign w_mem_valid = !rst && w_can_issue &&
                       ((w_grant_i && i_ibus_valid) || (w_grant_d && i_dbus_valid));
  assign w_accept    = w_mem_valid && i_mem_ready;

  always_comb begin
    o_mem_addr  = '0;
    o_mem_wen   = 1'b0;
    o_mem_wdata = '0;
    o_mem_wmask = '0;
    if (w_mem_valid) begin
      if (w_grant_i) begin
        o_mem_addr  = i_ibus_addr;
        o_mem_wen   = i_ibus_wen;
        o_mem_wdata = i_ibus_wdata;
        o_mem_wmask = i_ibus_wmask;
      end else begin
        o_mem_addr  = i_dbus_addr;
        o_mem_wen   = i_dbus_wen;
        o_mem_wdata = i_dbus_wdata;
        o_mem_wmask = i_dbus_wmask;
      end
    end
  end

  assign o_mem_valid   = w_mem_valid;
  assign o_ibus_ready  = !rst && w_can_issue && i_mem_ready && w_grant_i;
  assign o_dbus_ready  = !rst && w_can_issue && i_mem_ready && w_grant_d;
  assign o_ibus_rdata  = i_mem_rdata;
  assign o_dbus_rdata  = i_mem_rdata;
  assign o_ibus_rvalid = !rst && i_mem_rvalid && (r_owner == OWN_I);
  assign o_dbus_rvalid = !rst && i_mem_rvalid && (r_owner == OWN_D);
  assign err           = r_err;

  // Response in the same cycle as a new acceptance still routes to the old owner.
  always_comb begin
    w_owner_next  = r_owner;
    w_lock_next   = r_lock;
    w_starve_next = r_starve;
    w_err_next    = r_err;

    if (w_accept) begin
      w_owner_next = w_grant_i ? OWN_I : OWN_D;
    end else if (i_mem_rvalid) begin
      w_owner_next = OWN_IDLE;
    end

    if (w_accept) begin
      w_lock_next = LOCK_NONE;
    end else if (w_mem_valid) begin
      w_lock_next = w_grant_i ? LOCK_I : LOCK_D;
    end

    if (!i_ibus_valid || (w_accept && w_grant_i)) begin
      w_starve_next = 4'd0;
    end else if (w_accept && w_grant_d && (r_starve < LIMIT)) begin
      w_starve_next = r_starve + 4'd1;
    end

    if (i_mem_rvalid && (r_owner == OWN_IDLE)) begin
      w_err_next = 1'b1;
    end
  end

endmodule

// File: tb/tb_membus_arbiter.sv
// Directed bench for membus_arbiter: the bench plays both masters and the memory slave cycle by cycle.
// Inputs change 1 ns after the rising edge; outputs are checked 2 ns after it.
module tb_membus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_ibus_valid, o_ibus_ready, i_ibus_wen, o_ibus_rvalid;
  logic [31:0] i_ibus_addr, i_ibus_wdata, o_ibus_rdata;
  logic [3:0]  i_ibus_wmask;
  logic        i_dbus_valid, o_dbus_ready, i_dbus_wen, o_dbus_rvalid;
  logic [31:0] i_dbus_addr, i_dbus_wdata, o_dbus_rdata;
  logic [3:0]  i_dbus_wmask;
  logic        o_mem_valid, i_mem_ready, o_mem_wen, i_mem_rvalid;
  logic [31:0] o_mem_addr, o_mem_wdata, i_mem_rdata;
  logic [3:0]  o_mem_wmask;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  membus_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .i_ibus_valid(i_ibus_valid), .o_ibus_ready(o_ibus_ready), .i_ibus_addr(i_ibus_addr),
    .i_ibus_wen(i_ibus_wen), .i_ibus_wdata(i_ibus_wdata), .i_ibus_wmask(i_ibus_wmask),
    .o_ibus_rdata(o_ibus_rdata), .o_ibus_rvalid(o_ibus_rvalid),
    .i_dbus_valid(i_dbus_valid), .o_dbus_ready(o_dbus_ready), .i_dbus_addr(i_dbus_addr),
    .i_dbus_wen(i_dbus_wen), .i_dbus_wdata(i_dbus_wdata), .i_dbus_wmask(i_dbus_wmask),
    .o_dbus_rdata(o_dbus_rdata), .o_dbus_rvalid(o_dbus_rvalid),
    .o_mem_valid(o_mem_valid), .i_mem_ready(i_mem_ready), .o_mem_addr(o_mem_addr),
    .o_mem_wen(o_mem_wen), .o_mem_wdata(o_mem_wdata), .o_mem_wmask(o_mem_wmask),
    .i_mem_rdata(i_mem_rdata), .i_mem_rvalid(i_mem_rvalid),
    .err(err)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_ibus_valid = 1'b0; i_ibus_addr = '0; i_ibus_wen = 1'b0; i_ibus_wdata = '0; i_ibus_wmask = '0;
    i_dbus_valid = 1'b0; i_dbus_addr = '0; i_dbus_wen = 1'b0; i_dbus_wdata = '0; i_dbus_wmask = '0;
    i_mem_ready  = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    i_ibus_valid = 1'b1; i_ibus_addr = 32'h40;
    i_mem_ready = 1'b1; i_mem_rvalid = 1'b1;
    next_cycle();
    next_cycle();
    #1;
    n_checks++; if (o_mem_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mem_valid got=%0h exp=0", o_mem_valid); end
    n_checks++; if (o_ibus_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ibus_ready got=%0h exp=0", o_ibus_ready); end
    n_checks++; if (o_ibus_rvalid !== 1'b0 || o_dbus_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got=%0h/%0h exp=0/0", o_ibus_rvalid, o_dbus_rvalid); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%0h exp=0", err); end
    next_cycle();
    rst = 1'b0;
    clear_inputs();
    $display("reset: outputs held low");
  endtask

  task automatic test_ibus_read();
    next_cycle();
    i_ibus_valid = 1'b1; i_ibus_addr = 32'h100; i_mem_ready = 1'b1;
    #1;
    n_checks++; if (o_mem_valid !== 1'b1 || o_mem_addr !== 32'h100) begin n_fail++; $display("FAIL rd_issue got valid=%0h addr=%0h exp valid=1 addr=100", o_mem_valid, o_mem_addr); end
    n_checks++; if (o_ibus_ready !== 1'b1 || o_dbus_ready !== 1'b0) begin n_fail++; $display("FAIL rd_ready got i=%0h d=%0h exp i=1 d=0", o_ibus_ready, o_dbus_ready); end
    next_cycle();
    i_ibus_valid = 1'b0;
    next_cycle();
    i_mem_rvalid = 1'b1; i_mem_rdata = 32'hDEADBEEF;
    #1;
    n_checks++; if (o_ibus_rvalid !== 1'b1 || o_ibus_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_resp got rvalid=%0h rdata=%0h exp rvalid=1 rdata=deadbeef", o_ibus_rvalid, o_ibus_rdata); end
    n_checks++; if (o_dbus_rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_dbus_rvalid got=%0h exp=0", o_dbus_rvalid); end
    next_cycle();
    // Owner must be back to idle: a new request issues with no response pending.
    i_mem_rvalid = 1'b0; i_ibus_valid = 1'b1; i_ibus_addr = 32'h104;
    #1;
    n_checks++; if (o_mem_valid !== 1'b1 || o_ibus_ready !== 1'b1) begin n_fail++; $display("FAIL rd_owner_idle got valid=%0h ready=%0h exp 1/1", o_mem_valid, o_ibus_ready); end
    next_cycle();
    i_ibus_valid = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h0;
    next_cycle();
    clear_inputs();
    $display("ibus read 0x100 -> %08h", 32'hDEADBEEF);
  endtask

  task automatic test_both_valid();
    next_cycle();
    i_ibus_valid = 1'b1; i_ibus_addr = 32'h104;
    i_dbus_valid = 1'b1; i_dbus_addr = 32'h2000; i_mem_ready = 1'b1;
    #1;
    n_checks++; if (o_mem_addr !== 32'h2000 || o_dbus_ready !== 1'b1 || o_ibus_ready !== 1'b0) begin n_fail++; $display("FAIL both_first got addr=%0h d=%0h i=%0h exp addr=2000 d=1 i=0", o_mem_addr, o_dbus_ready, o_ibus_ready); end
    next_cycle();
    i_dbus_valid = 1'b0;
    #1;
    n_checks++; if (o_mem_valid !== 1'b0 || o_ibus_ready !== 1'b0 || o_mem_addr !== 32'h0) begin n_fail++; $display("FAIL both_busy got valid=%0h ready=%0h addr=%0h exp 0/0/0", o_mem_valid, o_ibus_ready, o_mem_addr); end
    next_cycle();
    i_mem_rvalid = 1'b1; i_mem_rdata = 32'hAAAA0001;
    #1;
    n_checks++; if (o_dbus_rvalid !== 1'b1 || o_ibus_rvalid !== 1'b0) begin n_fail++; $display("FAIL both_dresp got d=%0h i=%0h exp d=1 i=0", o_dbus_rvalid, o_ibus_rvalid); end
    n_checks++; if (o_mem_valid !== 1'b1 || o_mem_addr !== 32'h104 || o_ibus_ready !== 1'b1) begin n_fail++; $display("FAIL both_b2b got valid=%0h addr=%0h ready=%0h exp 1/104/1", o_mem_valid, o_mem_addr, o_ibus_ready); end
    next_cycle();
    i_ibus_valid = 1'b0; i_mem_rdata = 32'hBBBB0002;
    #1;
    n_checks++; if (o_ibus_rvalid !== 1'b1 || o_dbus_rvalid !== 1'b0 || o_ibus_rdata !== 32'hBBBB0002) begin n_fail++; $display("FAIL both_iresp got i=%0h d=%0h rdata=%0h exp 1/0/bbbb0002", o_ibus_rvalid, o_dbus_rvalid, o_ibus_rdata); end
    next_cycle();
    clear_inputs();
    $display("both valid: dbus 0x2000 then ibus 0x104");
  endtask

  task automatic test_starvation();
    logic gi, prev_gi;
    prev_gi = 1'b0;
    for (int k = 0; k < 11; k++) begin
      next_cycle();
      i_ibus_valid = (k < 10); i_ibus_addr = 32'h200;
      i_dbus_valid = (k < 10); i_dbus_addr = 32'h3000;
      i_mem_ready = 1'b1; i_mem_rvalid = (k > 0); i_mem_rdata = 32'h1000 + k;
      gi = (k == 4) || (k == 9);
      #1;
      if (k < 10) begin
        n_checks++; if (o_ibus_ready !== gi || o_dbus_ready !== !gi) begin n_fail++; $display("FAIL starve_grant k=%0d got i=%0h d=%0h exp i=%0h d=%0h", k, o_ibus_ready, o_dbus_ready, gi, !gi); end
      end
      if (k > 0) begin
        n_checks++; if (o_ibus_rvalid !== prev_gi || o_dbus_rvalid !== !prev_gi) begin n_fail++; $display("FAIL starve_route k=%0d got i=%0h d=%0h exp i=%0h d=%0h", k, o_ibus_rvalid, o_dbus_rvalid, prev_gi, !prev_gi); end
      end
      if (k < 10) $display("starve cycle %0d: granted %s", k, gi ? "ibus" : "dbus");
      prev_gi = gi;
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_lock();
    next_cycle();
    i_ibus_valid = 1'b1; i_ibus_addr = 32'h300; i_mem_ready = 1'b0;
    #1;
    n_checks++; if (o_mem_valid !== 1'b1 || o_mem_addr !== 32'h300 || o_ibus_ready !== 1'b0) begin n_fail++; $display("FAIL lock_c1 got valid=%0h addr=%0h ready=%0h exp 1/300/0", o_mem_valid, o_mem_addr, o_ibus_ready); end
    for (int c = 2; c <= 3; c++) begin
      next_cycle();
      i_dbus_valid = 1'b1; i_dbus_addr = 32'h4000;
      #1;
      n_checks++; if (o_mem_addr !== 32'h300 || o_dbus_ready !== 1'b0 || o_ibus_ready !== 1'b0) begin n_fail++; $display("FAIL lock_c%0d got addr=%0h d=%0h i=%0h exp 300/0/0", c, o_mem_addr, o_dbus_ready, o_ibus_ready); end
    end
    next_cycle();
    i_mem_ready = 1'b1;
    #1;
    n_checks++; if (o_mem_addr !== 32'h300 || o_ibus_ready !== 1'b1 || o_dbus_ready !== 1'b0) begin n_fail++; $display("FAIL lock_accept got addr=%0h i=%0h d=%0h exp 300/1/0", o_mem_addr, o_ibus_ready, o_dbus_ready); end
    next_cycle();
    i_ibus_valid = 1'b0; i_mem_rvalid = 1'b1;
    #1;
    n_checks++; if (o_ibus_rvalid !== 1'b1 || o_mem_addr !== 32'h4000 || o_dbus_ready !== 1'b1) begin n_fail++; $display("FAIL lock_next got rvalid=%0h addr=%0h d=%0h exp 1/4000/1", o_ibus_rvalid, o_mem_addr, o_dbus_ready); end
    next_cycle();
    i_dbus_valid = 1'b0;
    #1;
    n_checks++; if (o_dbus_rvalid !== 1'b1 || o_ibus_rvalid !== 1'b0) begin n_fail++; $display("FAIL lock_dresp got d=%0h i=%0h exp 1/0", o_dbus_rvalid, o_ibus_rvalid); end
    next_cycle();
    clear_inputs();
    $display("locked ibus 0x300 held for 3 stall cycles, then dbus 0x4000");
  endtask

  task automatic test_write();
    next_cycle();
    i_dbus_valid = 1'b1; i_dbus_addr = 32'h5000; i_dbus_wen = 1'b1;
    i_dbus_wdata = 32'h12345678; i_dbus_wmask = 4'b0011; i_mem_ready = 1'b1;
    #1;
    n_checks++; if (o_mem_valid !== 1'b1 || o_mem_addr !== 32'h5000 || o_mem_wen !== 1'b1) begin n_fail++; $display("FAIL wr_fields got valid=%0h addr=%0h wen=%0h exp 1/5000/1", o_mem_valid, o_mem_addr, o_mem_wen); end
    n_checks++; if (o_mem_wdata !== 32'h12345678 || o_mem_wmask !== 4'b0011) begin n_fail++; $display("FAIL wr_data got wdata=%0h wmask=%0h exp 12345678/3", o_mem_wdata, o_mem_wmask); end
    next_cycle();
    i_dbus_valid = 1'b0; i_dbus_wen = 1'b0; i_mem_rvalid = 1'b1;
    #1;
    n_checks++; if (o_dbus_rvalid !== 1'b1 || o_mem_wen !== 1'b0) begin n_fail++; $display("FAIL wr_resp got rvalid=%0h wen=%0h exp 1/0", o_dbus_rvalid, o_mem_wen); end
    next_cycle();
    i_mem_rvalid = 1'b0;
    #1;
    n_checks++; if (o_dbus_rvalid !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL wr_after got rvalid=%0h err=%0h exp 0/0", o_dbus_rvalid, err); end
    clear_inputs();
    $display("dbus write 0x5000 <- 12345678 mask 0011");
  endtask

  task automatic test_stray_err();
    next_cycle();
    i_mem_rvalid = 1'b1; i_mem_rdata = 32'hCAFE0000;
    #1;
    n_checks++; if (o_ibus_rvalid !== 1'b0 || o_dbus_rvalid !== 1'b0) begin n_fail++; $display("FAIL stray_route got i=%0h d=%0h exp 0/0", o_ibus_rvalid, o_dbus_rvalid); end
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      i_mem_rvalid = 1'b0;
      #1;
      n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL stray_err_sticky c=%0d got=%0h exp=1", c, err); end
    end
    next_cycle();
    rst = 1'b1; i_ibus_valid = 1'b1; i_ibus_addr = 32'h80; i_mem_ready = 1'b1;
    #1;
    n_checks++; if (o_mem_valid !== 1'b0 || o_ibus_ready !== 1'b0) begin n_fail++; $display("FAIL stray_rst_outputs got valid=%0h ready=%0h exp 0/0", o_mem_valid, o_ibus_ready); end
    next_cycle();
    rst = 1'b0; clear_inputs();
    #1;
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL stray_rst_err got=%0h exp=0", err); end
    $display("stray response: err set, cleared by rst");
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_ibus_read();
    test_both_valid();
    test_starvation();
    test_lock();
    test_write();
    test_stray_err();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
